// File: rtl/sys_regfile.sv
// -----------------------------------------------------------------------------
// sys_regfile
//
// Register file sitting directly behind the system controller. It holds the ALU
// operands and the system configuration. The controller issues single-port
// write/read requests; reads return registered data one cycle later together
// with a one-cycle valid strobe. Entries 0..3 are also exported continuously:
//   entry 0 -> reg0        (ALU operand A)
//   entry 1 -> reg1        (ALU operand B)
//   entry 2 -> uart_config (bit0 parity_en, bit1 parity_type, [7:2] prescale)
//   entry 3 -> div_ratio   (clock divider ratio)
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   synchronous, active-high reset
//   address       in   entry index for the write or read
//   wr_en         in   write request (single-cycle or held)
//   rd_en         in   read request (single-cycle or held)
//   wrdata        in   write data
//   rddata        out  registered read data (holds last value when idle)
//   rddata_valid  out  high for one cycle per accepted read, aligned with rddata
//   reg0, reg1, uart_config, div_ratio  out  views of entries 0..3
//
// Handshake: there is no back-pressure. A request is accepted on every rising
// edge where it is asserted; a held request is accepted again every cycle.
// rddata_valid is asserted in the cycle after each accepted read.
//
// Configuration macro REGFILE_RDW_EN:
//   undefined (default) - simultaneous wr_en and rd_en: write wins, read dropped.
//   defined             - both happen; the read is write-through, so rddata
//                         returns wrdata (there is only one address bus).
// -----------------------------------------------------------------------------
module sys_regfile #(
  parameter int                    data_width    = 8,
  parameter int                    address_width = 3,
  parameter logic [data_width-1:0] reg2_rst      = 8'b1000_0001,
  parameter logic [data_width-1:0] reg3_rst      = 8'd32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [address_width-1:0] address,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [data_width-1:0]    wrdata,
  output logic [data_width-1:0]    rddata,
  output logic                     rddata_valid,
  output logic [data_width-1:0]    reg0,
  output logic [data_width-1:0]    reg1,
  output logic [data_width-1:0]    uart_config,
  output logic [data_width-1:0]    div_ratio
);

  localparam int depth = 1 << address_width;

  // The read-output register behaves as a two-state machine; its state is
  // exported directly as rddata_valid.
  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_VALID = 1'b1
  } rd_state_t;

  logic [data_width-1:0] mem [depth];
  rd_state_t             rd_state;
  rd_state_t             rd_state_next;
  logic [data_width-1:0] rddata_next;
  logic                  rd_accept;

  // Entry storage
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < depth; i++) begin
        mem[i] <= '0;
      end
      mem[2] <= reg2_rst;
      mem[3] <= reg3_rst;
    end else if (wr_en) begin
      mem[address] <= wrdata;
    end
  end

  // Read acceptance and next read-register contents
  always_comb begin
    rd_accept     = 1'b0;
    rddata_next   = rddata;
    rd_state_next = RD_IDLE;
`ifdef REGFILE_RDW_EN
    rd_accept = rd_en;
    if (rd_accept) begin
      // Same address bus for both ports, so a concurrent write always hits
      // the entry being read: forward the new data.
      rddata_next = wr_en ? wrdata : mem[address];
    end
`else
    rd_accept = rd_en && !wr_en;
    if (rd_accept) begin
      rddata_next = mem[address];
    end
`endif
    if (rd_accept) begin
      rd_state_next = RD_VALID;
    end
  end

  // Read-output register
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state <= RD_IDLE;
      rddata   <= '0;
    end else begin
      rd_state <= rd_state_next;
      rddata   <= rddata_next;
    end
  end

  assign rddata_valid = (rd_state == RD_VALID);

  assign reg0        = mem[0];
  assign reg1        = mem[1];
  assign uart_config = mem[2];
  assign div_ratio   = mem[3];

endmodule

// File: tb/tb_sys_regfile.sv
// -----------------------------------------------------------------------------
// tb_sys_regfile
//
// Bench for sys_regfile. A behavioural model (array of entries plus the last
// read result) is advanced by the step task on every clock edge; the scenario
// tasks compare the DUT outputs with the model and with directed constants.
// -----------------------------------------------------------------------------
module tb_sys_regfile;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          reset;
  logic [AW-1:0] address;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] wrdata;
  logic [DW-1:0] rddata;
  logic          rddata_valid;
  logic [DW-1:0] reg0;
  logic [DW-1:0] reg1;
  logic [DW-1:0] uart_config;
  logic [DW-1:0] div_ratio;

  int checks;
  int failures;

  // Reference model
  logic [DW-1:0] exp_mem [DEPTH];
  logic [DW-1:0] exp_rddata;
  logic          exp_valid;
  logic [DW-1:0] exp_q[$];

  sys_regfile #(
    .data_width   (DW),
    .address_width(AW),
    .reg2_rst     (8'h81),
    .reg3_rst     (8'd32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .wrdata      (wrdata),
    .rddata      (rddata),
    .rddata_valid(rddata_valid),
    .reg0        (reg0),
    .reg1        (reg1),
    .uart_config (uart_config),
    .div_ratio   (div_ratio)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the model at the edge, and return
  // 1 time unit after the edge so outputs can be sampled.
  task automatic step(input logic rst, input logic we, input logic re,
                      input logic [AW-1:0] a, input logic [DW-1:0] wd);
    logic read_ok;
    reset   = rst;
    wr_en   = we;
    rd_en   = re;
    address = a;
    wrdata  = wd;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
      exp_mem[2] = 8'h81;
      exp_mem[3] = 8'd32;
      exp_rddata = '0;
      exp_valid  = 1'b0;
    end else begin
`ifdef REGFILE_RDW_EN
      read_ok = re;
`else
      read_ok = re && !we;
`endif
      if (read_ok) begin
        exp_rddata = we ? wd : exp_mem[a];
        exp_q.push_back(exp_rddata);
      end
      exp_valid = read_ok;
      if (we) exp_mem[a] = wd;
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    checks++;
    if (reg0 !== 8'h00) begin
      failures++; $display("FAIL reset_reg0 got=%h exp=%h", reg0, 8'h00);
    end
    checks++;
    if (reg1 !== 8'h00) begin
      failures++; $display("FAIL reset_reg1 got=%h exp=%h", reg1, 8'h00);
    end
    checks++;
    if (uart_config !== 8'h81) begin
      failures++; $display("FAIL reset_uart_config got=%h exp=%h", uart_config, 8'h81);
    end
    checks++;
    if (div_ratio !== 8'd32) begin
      failures++; $display("FAIL reset_div_ratio got=%h exp=%h", div_ratio, 8'd32);
    end
    checks++;
    if (rddata !== 8'h00 || rddata_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_read got=%h/%b exp=00/0", rddata, rddata_valid);
    end
  endtask

  task automatic test_write_read();
    step(1'b0, 1'b1, 1'b0, 3'd5, 8'h5A);
    checks++;
    if (rddata_valid !== 1'b0) begin
      failures++; $display("FAIL wr_no_valid got=%b exp=0", rddata_valid);
    end
    step(1'b0, 1'b0, 1'b1, 3'd5, 8'h00);
    checks++;
    if (rddata !== 8'h5A || rddata_valid !== 1'b1) begin
      failures++;
      $display("FAIL wr_then_rd got=%h/%b exp=5a/1", rddata, rddata_valid);
    end
    step(1'b0, 1'b0, 1'b0, 3'd5, 8'h00);
    checks++;
    if (rddata !== 8'h5A || rddata_valid !== 1'b0) begin
      failures++;
      $display("FAIL rd_drop got=%h/%b exp=5a/0", rddata, rddata_valid);
    end
  endtask

  task automatic test_operand_export();
    step(1'b0, 1'b1, 1'b0, 3'd0, 8'd12);
    checks++;
    if (reg0 !== 8'd12) begin
      failures++; $display("FAIL export_reg0 got=%0d exp=12", reg0);
    end
    step(1'b0, 1'b1, 1'b0, 3'd1, 8'd7);
    checks++;
    if (reg1 !== 8'd7 || reg0 !== 8'd12) begin
      failures++; $display("FAIL export_reg1 got=%0d/%0d exp=7/12", reg1, reg0);
    end
    checks++;
    if (div_ratio !== 8'd32) begin
      failures++; $display("FAIL export_div_ratio got=%0d exp=32", div_ratio);
    end
  endtask

  task automatic test_held_read();
    logic [DW-1:0] exp_list [4];
    exp_list[0] = 8'h00;
    exp_list[1] = 8'h00;
    exp_list[2] = 8'h81;
    exp_list[3] = 8'd32;
    step(1'b1, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, AW'(i), 8'h00);
      checks++;
      if (rddata !== exp_list[i] || rddata_valid !== 1'b1) begin
        failures++;
        $display("FAIL held_read[%0d] got=%h/%b exp=%h/1", i, rddata, rddata_valid,
                 exp_list[i]);
      end
    end
    step(1'b0, 1'b0, 1'b0, '0, '0);
    checks++;
    if (rddata_valid !== 1'b0 || rddata !== 8'd32) begin
      failures++;
      $display("FAIL held_read_end got=%h/%b exp=20/0", rddata, rddata_valid);
    end
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] prev;
    prev = exp_rddata;
    step(1'b0, 1'b1, 1'b1, 3'd2, 8'hC4);
    checks++;
    if (uart_config !== 8'hC4) begin
      failures++; $display("FAIL simul_uart_config got=%h exp=c4", uart_config);
    end
    checks++;
`ifdef REGFILE_RDW_EN
    if (rddata !== 8'hC4 || rddata_valid !== 1'b1) begin
      failures++;
      $display("FAIL simul_read got=%h/%b exp=c4/1", rddata, rddata_valid);
    end
`else
    if (rddata !== prev || rddata_valid !== 1'b0) begin
      failures++;
      $display("FAIL simul_read got=%h/%b exp=%h/0", rddata, rddata_valid, prev);
    end
`endif
  endtask

  task automatic test_reset_mid_op();
    step(1'b0, 1'b0, 1'b1, 3'd2, 8'h00);
    step(1'b1, 1'b1, 1'b1, 3'd3, 8'hFF);
    checks++;
    if (div_ratio !== 8'd32) begin
      failures++; $display("FAIL rst_mid_div_ratio got=%h exp=20", div_ratio);
    end
    checks++;
    if (rddata_valid !== 1'b0 || rddata !== 8'h00) begin
      failures++;
      $display("FAIL rst_mid_read got=%h/%b exp=00/0", rddata, rddata_valid);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] exp_rd;
    int mism;
    exp_q.delete();
    mism = 0;
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
           DW'($urandom));
      if (rddata_valid === 1'b1 && exp_q.size() > 0) begin
        exp_rd = exp_q.pop_front();
        checks++;
        if (rddata !== exp_rd) begin
          failures++;
          $display("FAIL rand_rddata cyc=%0d got=%h exp=%h", n, rddata, exp_rd);
        end
      end
      checks++;
      if (rddata_valid !== exp_valid || rddata !== exp_rddata) begin
        failures++;
        $display("FAIL rand_read cyc=%0d got=%h/%b exp=%h/%b", n, rddata,
                 rddata_valid, exp_rddata, exp_valid);
      end
      checks++;
      if (reg0 !== exp_mem[0] || reg1 !== exp_mem[1] ||
          uart_config !== exp_mem[2] || div_ratio !== exp_mem[3]) begin
        failures++;
        $display("FAIL rand_views cyc=%0d got=%h %h %h %h exp=%h %h %h %h", n,
                 reg0, reg1, uart_config, div_ratio,
                 exp_mem[0], exp_mem[1], exp_mem[2], exp_mem[3]);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL rand_unreturned_reads got=%0d exp=0", exp_q.size());
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    address  = '0;
    wrdata   = '0;
    test_reset();
    test_write_read();
    test_operand_export();
    test_held_read();
    test_simultaneous();
    test_reset_mid_op();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sys_regfile.md
Name: sys_regfile

Overview:
Register file directly downstream of the system controller. It accepts the controller's single-port write/read requests (address, wr_en, rd_en, wrdata) and returns read data with a valid strobe (rddata, rddata_valid). It holds ALU operands and system configuration. Fixed-function entries are exported as static outputs to the ALU, UART and clock divider.

Parameters:
data_width, 8, width of each register entry and of the data buses
address_width, 3, address bus width; depth = 2**address_width entries
reg2_rst, 8'b1000_0001, reset value of entry 2 (UART config: parity enabled, even parity, prescale 32)
reg3_rst, 8'd32, reset value of entry 3 (clock divider ratio)

Ports:
clk  input  1  system clock; all logic on the rising edge
reset  input  1  synchronous, active-high reset
address  input  address_width  entry index for the write or read
wr_en  input  1  write request, single-cycle or held
rd_en  input  1  read request, single-cycle or held
wrdata  input  data_width  write data
rddata  output  data_width  registered read data
rddata_valid  output  1  high for one cycle per accepted read, aligned with rddata
reg0  output  data_width  entry 0, ALU operand A
reg1  output  data_width  entry 1, ALU operand B
uart_config  output  data_width  entry 2: bit0 parity_en, bit1 parity_type, bits[7:2] prescale
div_ratio  output  data_width  entry 3, clock-divider ratio

Behaviour:
- Reset is synchronous and active-high, sampled on the clk rising edge.
  - Entries 0, 1 and 4..depth-1 reset to 0.
  - Entry 2 resets to reg2_rst; entry 3 resets to reg3_rst.
  - rddata and rddata_valid reset to 0.
  - Reset overrides any wr_en/rd_en in the same cycle.
- Write:
  - wr_en=1 at edge N stores wrdata into entry[address] at edge N.
  - reg0/reg1/uart_config/div_ratio are continuous views of entries 0..3, so they show the new value after edge N.
  - A held wr_en rewrites the entry every cycle.
- Read:
  - rd_en=1 and wr_en=0 at edge N: rddata <= entry[address] and rddata_valid <= 1, both visible after edge N (1-cycle latency).
  - A held rd_en gives rddata_valid=1 every cycle, with rddata tracking the current address.
  - rd_en=0 gives rddata_valid=0 next cycle; rddata holds its last value.
- Simultaneous wr_en and rd_en: the write wins.
  - Entry is updated; read is dropped, rddata_valid=0 and rddata unchanged (default build).
- Every address in 0..depth-1 is legal; there is no out-of-range case.
- Read-to-write ordering: a read on the cycle after a write to the same address returns the new data.
- No internal state beyond the entries and the read-output register. The read register is effectively a 2-state idle/valid machine driven by rd_en.

Optional Feature:
Macro REGFILE_RDW_EN.
- Defined: simultaneous wr_en and rd_en performs both operations.
  - Read is write-through: rddata <= wrdata if the addresses match, else entry[address].
  - rddata_valid=1 next cycle.
  - One address bus means the addresses always match, so rddata equals wrdata.
- Undefined: write-wins behaviour as in Behaviour.

Test Plan:
1. Reset: assert reset for 2 cycles -> reg0=0, reg1=0, uart_config=8'h81, div_ratio=8'd32, rddata=0, rddata_valid=0.
2. Write then read:
   - Write 8'h5A to addr 5; one cycle later rd_en with addr 5.
   - Expect rddata=8'h5A and rddata_valid=1 exactly one cycle after rd_en, then valid=0 once rd_en drops.
3. Operand export: write 8'd12 to addr 0 and 8'd7 to addr 1 -> reg0=12, reg1=7 after the respective edges; div_ratio stays 32.
4. Held read:
   - rd_en high for 4 cycles, address stepping 0,1,2,3.
   - Expect rddata_valid high for 4 cycles with rddata = 0, 0, 8'h81, 8'd32 (after reset).
5. Simultaneous access: wr_en=rd_en=1, addr 2, wrdata 8'hC4.
   - Default build: uart_config=8'hC4, rddata_valid=0.
   - REGFILE_RDW_EN build: rddata=8'hC4 with rddata_valid=1.
6. Reset mid-operation: reset asserted in the same cycle as a write of 8'hFF to addr 3 -> div_ratio=32, no rddata_valid pulse.
